// File: rtl/icache_dm_pkg.sv
// icache_dm_pkg: shared address-map constants, FSM encoding and helpers for the instruction cache
package icache_dm_pkg;
  localparam int ADDR_BITS_DEF = 18;
  localparam int IO_HI = 17;
  localparam int IO_LO = 16;
  localparam logic [1:0] IO_SEL = 2'b11;
  typedef enum logic [1:0] {IDLE, REFILL, DRAIN} state_t;
  function automatic logic io_space(input logic [1:0] region);
    return region == IO_SEL;
  endfunction
endpackage

// File: rtl/icache_dm_if.sv
// icache_dm_if: fetch-side and memory-refill signals of the instruction cache
interface icache_dm_if;
  logic        flush_i;
  logic        if_re_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_inst_o;
  logic        if_done_o;
  logic        if_busy_o;
  logic        mem_re_o;
  logic [31:0] mem_addr_o;
  logic        mem_busy_i;
  logic        mem_done_i;
  logic [31:0] mem_data_i;
  modport slave (
    input  flush_i, if_re_i, if_addr_i, mem_busy_i, mem_done_i, mem_data_i,
    output if_inst_o, if_done_o, if_busy_o, mem_re_o, mem_addr_o
  );
  modport master (
    output flush_i, if_re_i, if_addr_i, mem_busy_i, mem_done_i, mem_data_i,
    input  if_inst_o, if_done_o, if_busy_o, mem_re_o, mem_addr_o
  );
endinterface

// File: rtl/icache_array.sv
// icache_array: valid/tag/data storage, one write port and one combinational read port
module icache_array #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] w_idx,
  input  logic [TAG_BITS-1:0]   w_tag,
  input  logic [31:0]           w_data,
  input  logic [INDEX_BITS-1:0] r_idx,
  output logic                  r_valid,
  output logic [TAG_BITS-1:0]   r_tag,
  output logic [31:0]           r_data
);
  localparam int LINES = 1 << INDEX_BITS;
  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [31:0]         words [LINES];
  always_ff @(posedge clk)
    if (!rst) valid <= '0;
    else if (we) valid[w_idx] <= 1'b1;
  // Tag and data are qualified by valid, so they carry no reset.
  always_ff @(posedge clk)
    if (we) begin
      tags[w_idx] <= w_tag;
      words[w_idx] <= w_data;
    end
  assign r_valid = valid[r_idx];
  assign r_tag = tags[r_idx];
  assign r_data = words[r_idx];
endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache, one word per line, 1-cycle hit
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_BITS = ADDR_BITS_DEF
) (
  input logic clk,
  input logic rst,
  input logic rdy,
  icache_dm_if.slave bus
);
  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;
  state_t state;
  logic [31:0] lat_addr, inst;
  logic done, we, hit, r_valid;
  logic [TAG_BITS-1:0] r_tag;
  logic [31:0] r_data;
  assign we = rst && rdy && state != IDLE && bus.mem_done_i && !io_space(lat_addr[IO_HI:IO_LO]);
  assign hit = r_valid && r_tag == bus.if_addr_i[ADDR_BITS-1:INDEX_BITS+2] && !io_space(bus.if_addr_i[IO_HI:IO_LO]);
  icache_array #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_array (
    .clk(clk),
    .rst(rst),
    .we(we),
    .w_idx(lat_addr[INDEX_BITS+1:2]),
    .w_tag(lat_addr[ADDR_BITS-1:INDEX_BITS+2]),
    .w_data(bus.mem_data_i),
    .r_idx(bus.if_addr_i[INDEX_BITS+1:2]),
    .r_valid(r_valid),
    .r_tag(r_tag),
    .r_data(r_data)
  );
  // A wrong-path fetch (branch taken) still lets the refill finish and install, but returns nothing.
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      lat_addr <= '0;
      inst <= '0;
      done <= 1'b0;
    end else if (rdy) begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (bus.if_re_i && !bus.flush_i) begin
            if (hit) begin
              inst <= r_data;
              done <= 1'b1;
            end else begin
              lat_addr <= bus.if_addr_i;
              state <= REFILL;
            end
          end
        REFILL:
          if (bus.mem_done_i) begin
            state <= IDLE;
            if (!bus.flush_i) begin
              inst <= bus.mem_data_i;
              done <= 1'b1;
            end
          end else if (bus.flush_i) state <= DRAIN;
        default:
          if (bus.mem_done_i) state <= IDLE;
      endcase
    end
  assign bus.if_inst_o = inst;
  assign bus.if_done_o = done && rdy && !bus.flush_i;
  assign bus.if_busy_o = state != IDLE;
  assign bus.mem_re_o = rdy && state != IDLE;
  assign bus.mem_addr_o = lat_addr;
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed fetches with a queued scoreboard and a latency-programmable memory responder
module tb_icache_dm;
  typedef struct {
    logic [31:0] d;
    logic        hit;
    int          cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst, rdy;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int lat = 2;
  int done_cyc = 0;
  exp_t exp_q[$];
  logic [31:0] mem_q[$];
  icache_dm_if bus();
  icache_dm dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  // Scoreboard monitor: every if_done_o pulse must match the oldest expectation.
  always @(negedge clk)
    if (bus.if_done_o) begin
      if (exp_q.size() == 0) chk("unexpected if_done_o", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("if_inst_o", bus.if_inst_o, e.d);
        chk("done cycle", cyc, e.hit ? e.cyc : done_cyc + 1);
      end
    end
  // Memory responder; decides at posedge+2 so stimulus for the coming edge is already settled.
  initial begin
    logic in_fl;
    logic [31:0] req;
    int cnt;
    in_fl = 1'b0;
    cnt = 0;
    req = '0;
    bus.mem_busy_i = 1'b0;
    bus.mem_done_i = 1'b0;
    bus.mem_data_i = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        in_fl = 1'b0;
        cnt = 0;
        bus.mem_done_i = 1'b0;
        bus.mem_busy_i = 1'b0;
      end else if (!rdy) begin
      end else if (bus.mem_done_i) begin
        bus.mem_done_i = 1'b0;
        in_fl = 1'b0;
      end else if (in_fl) begin
        cnt--;
        bus.mem_busy_i = cnt > 1;
        if (cnt == 0) begin
          bus.mem_done_i = 1'b1;
          bus.mem_data_i = req + 32'h13;
          done_cyc = cyc;
        end
      end else if (bus.mem_re_o) begin
        if (mem_q.size() == 0) chk("unexpected mem_re_o", bus.mem_addr_o, 32'hffff_ffff);
        else chk("mem_addr_o", bus.mem_addr_o, mem_q.pop_front());
        req = bus.mem_addr_o;
        in_fl = 1'b1;
        cnt = lat;
        bus.mem_busy_i = lat > 1;
      end
    end
  end
  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.if_busy_o && n < 60);
    chk("idle timeout", {31'd0, bus.if_busy_o}, 32'd0);
  endtask
  task automatic fetch(input logic [31:0] a, input logic hit, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.if_re_i = 1'b1;
    bus.if_addr_i = a;
    if (!hit) mem_q.push_back(a);
    exp_q.push_back('{d, hit, cyc + 1});
    @(posedge clk);
    #1;
    bus.if_re_i = 1'b0;
    wait_idle();
  endtask
  initial begin
    bus.if_re_i = 1'b0;
    bus.if_addr_i = '0;
    bus.flush_i = 1'b0;
    rdy = 1'b1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst if_done_o", {31'd0, bus.if_done_o}, 32'd0);
    chk("rst mem_re_o", {31'd0, bus.mem_re_o}, 32'd0);
    chk("rst if_busy_o", {31'd0, bus.if_busy_o}, 32'd0);
    chk("rst if_inst_o", bus.if_inst_o, 32'd0);
    chk("rst mem_addr_o", bus.mem_addr_o, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    fetch(32'h0000_0000, 1'b0, 32'h0000_0013);
    fetch(32'h0000_0000, 1'b1, 32'h0000_0013);
    lat = 5;
    fetch(32'h0000_0100, 1'b0, 32'h0000_0113);
    lat = 2;
    fetch(32'h0000_0000, 1'b0, 32'h0000_0013);
    fetch(32'h0003_0000, 1'b0, 32'h0003_0013);
    fetch(32'h0003_0000, 1'b0, 32'h0003_0013);
    // Branch taken while refilling 0x40: no return, but the line still lands.
    @(posedge clk);
    #1;
    bus.if_re_i = 1'b1;
    bus.if_addr_i = 32'h40;
    mem_q.push_back(32'h40);
    @(posedge clk);
    #1;
    bus.if_re_i = 1'b0;
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    wait_idle();
    fetch(32'h0000_0040, 1'b1, 32'h0000_0053);
    // Branch taken in the hit-return cycle swallows the pulse.
    @(posedge clk);
    #1;
    bus.if_re_i = 1'b1;
    bus.if_addr_i = 32'h40;
    @(posedge clk);
    #1;
    bus.if_re_i = 1'b0;
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    // Request together with flush is dropped.
    bus.if_re_i = 1'b1;
    bus.if_addr_i = 32'h200;
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.if_re_i = 1'b0;
    bus.flush_i = 1'b0;
    @(negedge clk);
    chk("re+flush busy", {31'd0, bus.if_busy_o}, 32'd0);
    chk("re+flush mem_re", {31'd0, bus.mem_re_o}, 32'd0);
    // Hit frozen by rdy=0 for 3 cycles: one pulse when rdy returns.
    @(posedge clk);
    #1;
    bus.if_re_i = 1'b1;
    bus.if_addr_i = 32'h40;
    exp_q.push_back('{32'h53, 1'b1, cyc + 4});
    @(posedge clk);
    #1;
    bus.if_re_i = 1'b0;
    rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rdy = 1'b1;
    repeat (2) @(negedge clk);
    // Reset mid-refill: refill abandoned, nothing installed, no pulse.
    @(posedge clk);
    #1;
    bus.if_re_i = 1'b1;
    bus.if_addr_i = 32'h80;
    mem_q.push_back(32'h80);
    @(posedge clk);
    #1;
    bus.if_re_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid-rst busy", {31'd0, bus.if_busy_o}, 32'd0);
    chk("mid-rst mem_re", {31'd0, bus.mem_re_o}, 32'd0);
    chk("mid-rst if_inst_o", bus.if_inst_o, 32'd0);
    chk("mid-rst mem_addr_o", bus.mem_addr_o, 32'd0);
    fetch(32'h0000_0000, 1'b0, 32'h0000_0013);
    fetch(32'h0000_0080, 1'b0, 32'h0000_0093);
    fetch(32'h0000_0080, 1'b1, 32'h0000_0093);
    repeat (4) @(negedge clk);
    chk("exp_q drained", exp_q.size(), 32'd0);
    chk("mem_q drained", mem_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
